// File: rtl/regfile_mp.sv
// Multi-port integer register file: combinational reads with write-through bypass,
// prioritised synchronous writes and a registered write-collision flag.
// Defining REGFILE_SCOREBOARD_EN adds per-register busy bits for hazard detection.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     waddr,
  input  logic [NUM_WR*XLEN-1:0]   wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*XLEN-1:0]   rdata,
  input  logic                     bypass_en,
  output logic                     wr_conflict,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic [NUM_RD-1:0]        rbusy
);

  logic [XLEN-1:0]   regs [NREGS];
  logic [AW-1:0]     wa   [NUM_WR];
  logic [XLEN-1:0]   wd   [NUM_WR];
  logic [AW-1:0]     ra   [NUM_RD];
  logic [NUM_WR-1:0] wr_eff;
  logic [NUM_RD-1:0] rd_hit;
  logic              conflict_nxt;

  // A write is effective unless it targets the hardwired zero register.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa[j]     = waddr[j*AW +: AW];
    assign wd[j]     = wdata[j*XLEN +: XLEN];
    assign wr_eff[j] = we[j] && !(ZERO_REG != 0 && waddr[j*AW +: AW] == '0);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign ra[i] = raddr[i*AW +: AW];
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (wr_eff[a] && wr_eff[b] && wa[a] == wa[b]) conflict_nxt = 1'b1;
      end
    end
  end

  // Ascending port order lets the highest-index writer land last and win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_eff[j]) regs[wa[j]] <= wd[j];
      end
      wr_conflict <= conflict_nxt;
    end
  end

  always_comb begin
    rdata  = '0;
    rd_hit = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdata[i*XLEN +: XLEN] = regs[ra[i]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (bypass_en && wr_eff[j] && wa[j] == ra[i]) begin
          rdata[i*XLEN +: XLEN] = wd[j];
          rd_hit[i]             = 1'b1;
        end
      end
      if (ZERO_REG != 0 && ra[i] == '0) rdata[i*XLEN +: XLEN] = '0;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] busy;

  // Set is applied after the clears so a newly issued producer keeps the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j]) busy[wa[j]] <= 1'b0;
      end
      if (sb_set && !(ZERO_REG != 0 && sb_addr == '0)) busy[sb_addr] <= 1'b1;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rbusy[i] = busy[ra[i]] && !rd_hit[i];
    end
  end
`else
  logic sb_unused;
  assign sb_unused = ^{sb_set, sb_addr, rd_hit};
  assign rbusy     = '0;
`endif

endmodule
